// File: rtl/if_prefetch_unit.sv
// Decoupled instruction prefetcher: issues in-order word fetches under a credit limit and buffers responses for ID.
// Optional same-cycle response bypass to ID is enabled by defining IF_PREFETCH_BYPASS_EN.

module if_prefetch_unit_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             overflow_i,
  input logic [CNT_W:0]   credit_i
);
  // Credit accounting must make a FIFO overflow impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!overflow_i);
      assert (credit_i <= (CNT_W+1)'(DEPTH));
    end
  end
endmodule

module if_prefetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_en_i,
  input  logic [ADDR_W-1:0]          redirect_addr_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [31:0]                imem_rdata_i,
  output logic                       id_valid_o,
  output logic [31:0]                id_inst_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [ADDR_W-1:0]          id_pc_next_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-3:0] fetch_word_q, fetch_word_d;
  logic [CNT_W-1:0]  count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pend_mem_q [DEPTH];

  logic [CNT_W:0] credit_s;
  logic fifo_empty_s, fifo_full_s, accept_s, resp_s, keep_s, bypass_s, push_s, pop_s;
  logic [1:0] unused_addr_bits_s;

  assign unused_addr_bits_s = redirect_addr_i[1:0];
  assign credit_s     = {1'b0, count_q} + {1'b0, outst_q};
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_q == CNT_W'(DEPTH));
  assign imem_req_o   = ~rst_i & ~redirect_en_i & (credit_s < (CNT_W+1)'(DEPTH));
  assign imem_addr_o  = {fetch_word_q, 2'b00};
  assign accept_s     = imem_req_o & imem_gnt_i;
  // Responses with nothing outstanding belong to requests issued before reset.
  assign resp_s       = imem_rvalid_i & (outst_q != {CNT_W{1'b0}});
  assign keep_s       = resp_s & ~redirect_en_i & (discard_q == {CNT_W{1'b0}});
`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass_s     = keep_s & fifo_empty_s;
`else
  assign bypass_s     = 1'b0;
`endif
  assign push_s       = keep_s & ~fifo_full_s & ~(bypass_s & id_ready_i);
  assign pop_s        = ~fifo_empty_s & id_ready_i & ~redirect_en_i;
  assign fifo_count_o = count_q;
  assign id_pc_next_o = id_pc_o + ADDR_W'(4);

  // ID-facing head selection; empty FIFO presents zeros.
  always_comb begin
    id_valid_o = ~fifo_empty_s | bypass_s;
    id_inst_o  = 32'h0;
    id_pc_o    = {ADDR_W{1'b0}};
    if (bypass_s) begin
      id_inst_o = imem_rdata_i;
      id_pc_o   = pend_mem_q[pend_rd_q];
    end else if (!fifo_empty_s) begin
      id_inst_o = inst_mem_q[rd_ptr_q];
      id_pc_o   = pc_mem_q[rd_ptr_q];
    end else begin
      id_inst_o = 32'h0;
      id_pc_o   = {ADDR_W{1'b0}};
    end
  end

  // Next-state for fetch PC, credits, discard count and FIFO pointers.
  always_comb begin
    fetch_word_d = fetch_word_q;
    count_d      = count_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_wr_d    = pend_wr_q;
    pend_rd_d    = pend_rd_q;
    overflow_d   = overflow_q | (keep_s & fifo_full_s);

    if (accept_s) begin
      fetch_word_d = fetch_word_q + (ADDR_W-2)'(1);
      pend_wr_d    = pend_wr_q + PTR_W'(1);
    end else begin
      fetch_word_d = fetch_word_q;
      pend_wr_d    = pend_wr_q;
    end

    if (resp_s) begin
      pend_rd_d = pend_rd_q + PTR_W'(1);
    end else begin
      pend_rd_d = pend_rd_q;
    end

    case ({accept_s, resp_s})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_en_i) begin
      // Everything still in flight after this cycle is stale.
      fetch_word_d = redirect_addr_i[ADDR_W-1:2];
      discard_d    = outst_q - (resp_s ? CNT_W'(1) : CNT_W'(0));
      rd_ptr_d     = wr_ptr_q;
      count_d      = {CNT_W{1'b0}};
    end else begin
      if (resp_s && (discard_q != {CNT_W{1'b0}})) begin
        discard_d = discard_q - CNT_W'(1);
      end else begin
        discard_d = discard_q;
      end
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_word_q <= RESET_PC[ADDR_W-1:2];
      count_q      <= {CNT_W{1'b0}};
      outst_q      <= {CNT_W{1'b0}};
      discard_q    <= {CNT_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      pend_wr_q    <= {PTR_W{1'b0}};
      pend_rd_q    <= {PTR_W{1'b0}};
      overflow_q   <= 1'b0;
    end else begin
      fetch_word_q <= fetch_word_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      overflow_q   <= overflow_d;
    end
  end

  // Data storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= pend_mem_q[pend_rd_q];
    end
    if (accept_s) begin
      pend_mem_q[pend_wr_q] <= imem_addr_o;
    end
  end

  if_prefetch_unit_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .overflow_i (overflow_q),
    .credit_i   (credit_s)
  );
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: vector table for streaming/backpressure, hand sequences for
// redirect, reset and PC wrap corners. An in-order memory model answers one cycle after grant unless held.

module tb_if_prefetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0, fully controlled by the bench.
  logic        rst0 = 1'b1, redir0 = 1'b0, gnt0 = 1'b1, ready0 = 1'b1, rv0 = 1'b0, hold0 = 1'b0;
  logic [31:0] raddr0 = 32'h0, rdata0 = 32'h0;
  logic        req0, valid0;
  logic [31:0] addr0, inst0, pc0, pcn0;
  logic [2:0]  cnt0;

  // DUT 1: RESET_PC = 0xFFFFFFF8, free-running for the wrap check.
  logic        rst1 = 1'b1, redir1 = 1'b0, gnt1 = 1'b1, ready1 = 1'b1, rv1 = 1'b0;
  logic [31:0] raddr1 = 32'h0, rdata1 = 32'h0;
  logic        req1, valid1;
  logic [31:0] addr1, inst1, pc1, pcn1;
  logic [2:0]  cnt1;

  if_prefetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_i(rst0), .redirect_en_i(redir0), .redirect_addr_i(raddr0),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_gnt_i(gnt0), .imem_rvalid_i(rv0),
    .imem_rdata_i(rdata0), .id_valid_o(valid0), .id_inst_o(inst0), .id_pc_o(pc0),
    .id_pc_next_o(pcn0), .id_ready_i(ready0), .fifo_count_o(cnt0));

  if_prefetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk_i(clk), .rst_i(rst1), .redirect_en_i(redir1), .redirect_addr_i(raddr1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_gnt_i(gnt1), .imem_rvalid_i(rv1),
    .imem_rdata_i(rdata1), .id_valid_o(valid1), .id_inst_o(inst1), .id_pc_o(pc1),
    .id_pc_next_o(pcn1), .id_ready_i(ready1), .fifo_count_o(cnt1));

  int n_checks = 0;
  int n_errors = 0;
  int acc_total = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] pops1_pc [4];
  logic [31:0] pops1_pcn[4];
  logic [31:0] pops1_ins[4];
  int          pops1_n = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc, input logic [2:0] e_cnt);
    chk({tag, "_req"},   {31'h0, req0},   {31'h0, e_req});
    chk({tag, "_addr"},  addr0,           e_addr);
    chk({tag, "_valid"}, {31'h0, valid0}, {31'h0, e_valid});
    chk({tag, "_count"}, {29'h0, cnt0},   {29'h0, e_cnt});
    if (e_valid) begin
      chk({tag, "_pc"},      pc0,   e_pc);
      chk({tag, "_pc_next"}, pcn0,  e_pc + 32'd4);
      chk({tag, "_inst"},    inst0, mem_word(e_pc));
    end else begin
      chk({tag, "_pc_empty"},   pc0,   32'h0);
      chk({tag, "_inst_empty"}, inst0, 32'h0);
    end
  endtask

  // Called at the negedge: capture this cycle's handshakes, cross the edge, update the memory models.
  task automatic finish_cycle();
    logic c_acc0, c_rv0, c_rst0, c_acc1, c_rv1, c_rst1;
    logic [31:0] c_addr0, c_addr1;
    c_acc0 = req0 & gnt0; c_addr0 = addr0; c_rv0 = rv0; c_rst0 = rst0;
    c_acc1 = req1 & gnt1; c_addr1 = addr1; c_rv1 = rv1; c_rst1 = rst1;
    if (c_rst0) acc_total = 0;
    else if (c_acc0) acc_total++;
    if (!c_rst1 && valid1 && ready1 && pops1_n < 4) begin
      pops1_pc[pops1_n]  = pc1;
      pops1_pcn[pops1_n] = pcn1;
      pops1_ins[pops1_n] = inst1;
      pops1_n++;
    end
    @(posedge clk);
    #1;
    if (c_rst0) q0.delete();
    else begin
      if (c_rv0) void'(q0.pop_front());
      if (c_acc0) q0.push_back(c_addr0);
    end
    rv0    = !hold0 && (q0.size() != 0);
    rdata0 = rv0 ? mem_word(q0[0]) : 32'h0;
    if (c_rst1) q1.delete();
    else begin
      if (c_rv1) void'(q1.pop_front());
      if (c_acc1) q1.push_back(c_addr1);
    end
    rv1    = (q1.size() != 0);
    rdata1 = rv1 ? mem_word(q1[0]) : 32'h0;
  endtask

  task automatic do_reset();
    rst0 = 1'b1; redir0 = 1'b0; hold0 = 1'b0;
    @(negedge clk); finish_cycle();
    @(negedge clk); finish_cycle();
    rst0 = 1'b0;
  endtask

  typedef struct {
    logic        rst, rdy, gnt, chk_all, e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[19];
  logic [31:0] wrap_pc[4];

  initial begin
    // Streaming fetch with ready=1, then backpressure from empty with ready=0.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 3'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 3'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 3'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 3'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 3'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0, 3'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 3'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 3'd4};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 3'd4};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 3'd4};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4, 3'd3};
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000; wrap_pc[3] = 32'h0000_0004;

    @(negedge clk); finish_cycle();
    rst1 = 1'b0;

    for (int i = 0; i < 19; i++) begin
      rst0 = vecs[i].rst; ready0 = vecs[i].rdy; gnt0 = vecs[i].gnt;
      @(negedge clk);
      if (vecs[i].chk_all)
        check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                  vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_cnt);
      else
        chk($sformatf("vec%0d_req", i), {31'h0, req0}, {31'h0, vecs[i].e_req});
      if (i == 16) chk("bp_accepted", acc_total, 32'd4);
      finish_cycle();
    end

    // Redirect with two responses in flight and one entry buffered.
    do_reset(); ready0 = 1'b0; gnt0 = 1'b1;
    @(negedge clk); finish_cycle();
    hold0 = 1'b1;
    @(negedge clk); finish_cycle();
    @(negedge clk); finish_cycle();
    redir0 = 1'b1; raddr0 = 32'h0000_0103;
    @(negedge clk);
    chk("redir_req_blocked", {31'h0, req0}, 32'h0);
    chk("redir_pre_count", {29'h0, cnt0}, 32'd1);
    finish_cycle();
    redir0 = 1'b0; hold0 = 1'b0;
    @(negedge clk); check_out("redir_next", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0); finish_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("redir_stale%0d_valid", k), {31'h0, valid0}, 32'h0);
      chk($sformatf("redir_stale%0d_count", k), {29'h0, cnt0}, 32'h0);
      finish_cycle();
    end
    ready0 = 1'b1;
    @(negedge clk); check_out("redir_first", 1'b0, 32'h110, 1'b1, 32'h100, 3'd1); finish_cycle();
    @(negedge clk); check_out("redir_second", 1'b1, 32'h110, 1'b1, 32'h104, 3'd1); finish_cycle();

    // Redirect coinciding with a response and an ID pop.
    do_reset(); ready0 = 1'b0; gnt0 = 1'b1;
    @(negedge clk); finish_cycle();
    @(negedge clk); finish_cycle();
    redir0 = 1'b1; raddr0 = 32'h0000_0200; ready0 = 1'b1;
    @(negedge clk);
    chk("coll_pre_valid", {31'h0, valid0}, 32'h1);
    chk("coll_pre_rvalid", {31'h0, rv0}, 32'h1);
    chk("coll_req_blocked", {31'h0, req0}, 32'h0);
    finish_cycle();
    redir0 = 1'b0;
    @(negedge clk); check_out("coll_next", 1'b1, 32'h200, 1'b0, 32'h0, 3'd0); finish_cycle();
    @(negedge clk); check_out("coll_wait", 1'b1, 32'h204, 1'b0, 32'h0, 3'd0); finish_cycle();
    @(negedge clk); check_out("coll_first", 1'b1, 32'h208, 1'b1, 32'h200, 3'd1); finish_cycle();

    // Reset mid-stream with three entries buffered.
    do_reset(); ready0 = 1'b0; gnt0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); finish_cycle();
    end
    rst0 = 1'b1;
    @(negedge clk); chk("rst_pre_count", {29'h0, cnt0}, 32'd3); finish_cycle();
    @(negedge clk); check_out("rst_held", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0); finish_cycle();
    rst0 = 1'b0;
    @(negedge clk); check_out("rst_release", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0); finish_cycle();
    @(negedge clk); finish_cycle();
    @(negedge clk); check_out("rst_first", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1); finish_cycle();

    // PC wrap on the second instance.
    chk("wrap_pops", pops1_n, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap%0d_pc", k),      pops1_pc[k],  wrap_pc[k]);
      chk($sformatf("wrap%0d_pc_next", k), pops1_pcn[k], wrap_pc[k] + 32'd4);
      chk($sformatf("wrap%0d_inst", k),    pops1_ins[k], mem_word(wrap_pc[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It generalises the single-PC IF stage into a decoupled prefetcher. It issues sequential instruction requests to an instruction memory that has variable latency, and buffers up to DEPTH returned instructions in a FIFO. It hands {inst, pc, pc+4} to ID under a valid/ready handshake. Jump, branch and CP0 redirects flush the FIFO and discard any in-flight responses.

Parameters:
- ADDR_W, 32: width of PC and instruction address.
- DEPTH, 4: FIFO entries, which also caps outstanding requests; power of 2, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk, in, 1: main clock.
- rst, in, 1: synchronous, active-high reset.
- redirect_en, in, 1: change fetch stream (jump, branch or exception).
- redirect_addr, in, ADDR_W: new fetch PC; bits [1:0] ignored.
- imem_req, out, 1: fetch request valid.
- imem_addr, out, ADDR_W: fetch address, word aligned.
- imem_gnt, in, 1: memory accepts the request this cycle.
- imem_rvalid, in, 1: response valid; responses return in request order.
- imem_rdata, in, 32: fetched instruction.
- id_valid, out, 1: FIFO head valid.
- id_inst, out, 32: head instruction.
- id_pc, out, ADDR_W: head instruction address.
- id_pc_next, out, ADDR_W: id_pc + 4.
- id_ready, in, 1: ID consumes head this cycle.
- fifo_count, out, $clog2(DEPTH+1): buffered entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at the posedge.
- Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - Outputs in and after the reset cycle: imem_req=0, id_valid=0, fifo_count=0.
  - id_inst and id_pc read 0 while the FIFO is empty.
- Request issue: imem_req = ~rst & ~redirect_en & (fifo_count + outstanding < DEPTH).
  - imem_addr = fetch_pc, with the low 2 bits always 0.
- Request acceptance: a request is accepted when imem_req & imem_gnt.
  - On acceptance: fetch_pc += 4, wrapping mod 2^ADDR_W; outstanding += 1.
  - Each accepted request also pushes its address into an in-order pending-address queue of DEPTH entries.
  - imem_req and imem_addr may stay asserted across cycles until granted.
- Response handling: on imem_rvalid, outstanding -= 1 and the pending-address queue pops.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise {imem_rdata, pending address} is written to the FIFO tail.
  - The entry is visible on id_* in the next cycle (1-cycle response-to-ID latency).
- Pop: the FIFO head pops when id_valid & id_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Full and empty: the credit rule guarantees a response never arrives when the FIFO is full.
  - If it does, the data is dropped and sticky internal overflow is set; a verification assertion checks overflow stays 0.
  - Pop on empty is ignored.
- Redirect (redirect_en=1), taking priority over all same-cycle events:
  - FIFO cleared; fifo_count=0 next cycle.
  - fetch_pc = {redirect_addr[ADDR_W-1:2], 2'b00}.
  - discard = outstanding - (imem_rvalid ? 1 : 0), using the pre-redirect values.
  - No request is issued in the redirect cycle.
  - A same-cycle pop is void.
  - A same-cycle response is dropped.
- Back-to-back redirects: the last redirect wins; the discard count is recomputed each cycle.
- The first request to the new PC is issued the cycle after the redirect.
- Reset mid-operation: all state is cleared. Responses arriving after reset for pre-reset requests are not tracked; the memory is reset alongside.

Optional Feature:
- Macro: IF_PREFETCH_BYPASS_EN.
- When defined: if the FIFO is empty, discard=0, imem_rvalid=1 and redirect_en=0, the response drives id_* combinationally in the same cycle (0-cycle latency).
  - If id_ready is also 1, the entry is consumed and not written to the FIFO.
  - Otherwise it is written to the FIFO as normal.
- When undefined: response-to-ID latency is always exactly 1 cycle and id_* are purely registered.

Test Plan:
1. Sequential fetch, RESET_PC=0, gnt=1, rvalid one cycle after each grant, id_ready=1.
   - Required: id_pc sequence 0x0, 0x4, 0x8, 0xC.
   - Required: id_pc_next = id_pc + 4.
   - Required: id_inst matches memory.
2. Backpressure, id_ready=0, DEPTH=4.
   - Required: exactly 4 requests accepted, then imem_req=0 and fifo_count=4.
   - After id_ready=1 for one cycle: fifo_count=3 and imem_req reasserts.
3. Redirect with 2 responses in flight, redirect_addr=0x103.
   - Required: FIFO cleared.
   - Required: next imem_addr=0x100.
   - Required: the 2 stale responses are dropped.
   - Required: first id_pc=0x100.
4. Redirect in the same cycle as imem_rvalid, id_valid and id_ready.
   - Required: discard = outstanding - 1.
   - Required: no pop takes effect; the response is dropped.
   - Required: id_valid=0 next cycle.
5. PC wrap, RESET_PC=0xFFFFFFF8.
   - Required: id_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
6. rst asserted mid-stream with 3 entries buffered.
   - Required next cycle: fifo_count=0, id_valid=0, imem_req=0.
   - Required once rst is released: the first imem_addr is RESET_PC.
